dest_port_decoder: RTL and testbench

- Destination decoder stage for the FCUDA NoC: the inverse of the port encoder.
- Accepts a flit tagged with a binary destination index and decodes the index to a one-hot output-port valid vector.
- Buffers up to two flits in a registered skid FIFO and holds each flit until the selected port accepts it.
- Sits between the injection/arbitration logic and the per-port output links of a router.

---
 rtl/dest_port_decoder.sv | 104 ++++++++++
 tb/tb_dest_port_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dest_port_decoder.sv
// Destination decoder: buffers flits in a 2-entry skid FIFO and presents the head flit on a one-hot port-valid vector.
// Optional macro DEST_PORT_DECODER_DROP_CNT_EN adds a 16-bit saturating drop counter output.
module dest_port_decoder #(
    parameter int n = 4,
    parameter int m = 2,
    parameter int w = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [m-1:0] in_dest,
    input  logic [w-1:0] in_data,
    output logic [n-1:0] out_valid,
    input  logic [n-1:0] out_ready,
    output logic [w-1:0] out_data,
`ifdef DEST_PORT_DECODER_DROP_CNT_EN
    output logic [15:0]  drop_cnt,
`endif
    output logic         drop
);

    localparam logic [m:0] N_LIMIT = (m+1)'(n);

    logic [m-1:0] dest_mem [2];
    logic [w-1:0] data_mem [2];
    logic         head_reg;
    logic         tail_reg;
    logic [1:0]   count_reg;
    logic [1:0]   count_next;
    logic         drop_reg;

    logic         accept;
    logic         in_range;
    logic         push;
    logic         pop;
    logic [m-1:0] head_dest;

    assign in_ready  = (count_reg != 2'd2);
    assign accept    = in_valid & in_ready;
    assign in_range  = ({1'b0, in_dest} < N_LIMIT);
    assign push      = accept & in_range;
    assign head_dest = dest_mem[head_reg];
    assign out_data  = data_mem[head_reg];
    assign drop      = drop_reg;

    // Only the port the head targets is lit, so this masks out_ready down to that one bit.
    assign pop = |(out_valid & out_ready);

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_decode
            localparam logic [m-1:0] IDX = m'(gi);
            assign out_valid[gi] = (count_reg != 2'd0) && (head_dest == IDX);
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
            drop_reg  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dest_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            drop_reg  <= accept & ~in_range;
            if (push) begin
                dest_mem[tail_reg] <= in_dest;
                data_mem[tail_reg] <= in_data;
                tail_reg           <= ~tail_reg;
            end
            if (pop) begin
                head_reg <= ~head_reg;
            end
        end
    end

`ifdef DEST_PORT_DECODER_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= 16'd0;
        end else if (accept && !in_range && drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_dest_port_decoder.sv
// Directed bench for dest_port_decoder: a 4-port instance (n = 2^m) and a 3-port instance for out-of-range drops.
// Optional macro DEST_PORT_DECODER_DROP_CNT_EN enables drop counter checks.
module tb_dest_port_decoder;

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;

    // 4-port instance
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dest;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        drop;

    // 3-port instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_in_dest;
    logic [31:0] b_in_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [31:0] b_out_data;
    logic        b_drop;

`ifdef DEST_PORT_DECODER_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] b_drop_cnt;
`endif

    always #5 clk = ~clk;

    dest_port_decoder #(.n(4), .m(2), .w(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEST_PORT_DECODER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .drop      (drop)
    );

    dest_port_decoder #(.n(3), .m(2), .w(32)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_dest   (b_in_dest),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
`ifdef DEST_PORT_DECODER_DROP_CNT_EN
        .drop_cnt  (b_drop_cnt),
`endif
        .drop      (b_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("ok   %s observed=%0h", tag, obs);
        end else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          ds [4] = '{0, 1, 3, 0};
    logic [3:0]  exp_ov;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
        b_in_valid = 1'b0; b_in_dest = '0; b_in_data = '0; b_out_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'h0);

        // Single flit to port 2
        out_ready = 4'b1111;
        in_valid = 1'b1; in_dest = 2'd2; in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        chk("single_out_valid", 64'(out_valid), 64'h4);
        chk("single_out_data", 64'(out_data), 64'hA5A5_0001);
        tick();
        chk("single_drained", 64'(out_valid), 64'h0);

        // Back-to-back stream, one accept and one send per edge
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_dest  = 2'(ds[i]);
            in_data  = 32'hB000_0000 + 32'(i);
            if (i > 0) begin
                exp_ov = 4'b0001 << ds[i-1];
                chk($sformatf("stream%0d_out_valid", i-1), 64'(out_valid), 64'(exp_ov));
                chk($sformatf("stream%0d_out_data", i-1), 64'(out_data), 64'hB000_0000 + 64'(i-1));
                chk($sformatf("stream%0d_in_ready", i-1), 64'(in_ready), 64'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream3_out_valid", 64'(out_valid), 64'h1);
        chk("stream3_out_data", 64'(out_data), 64'hB000_0003);
        tick();
        chk("stream_drained", 64'(out_valid), 64'h0);

        // Head-of-line blocking on port 1
        out_ready = 4'b1101;
        in_valid = 1'b1; in_dest = 2'd1; in_data = 32'hC000_0001;
        tick();
        chk("block_head_valid", 64'(out_valid), 64'h2);
        in_dest = 2'd2; in_data = 32'hC000_0002;
        tick();
        chk("block_full_in_ready", 64'(in_ready), 64'd0);
        in_dest = 2'd3; in_data = 32'hC000_0003;
        tick();
        chk("block_still_full", 64'(in_ready), 64'd0);
        chk("block_head_stable", 64'(out_valid), 64'h2);
        chk("block_data_stable", 64'(out_data), 64'hC000_0001);
        out_ready = 4'b1111;
        tick();
        chk("unblock_in_ready", 64'(in_ready), 64'd1);
        chk("unblock_second_valid", 64'(out_valid), 64'h4);
        chk("unblock_second_data", 64'(out_data), 64'hC000_0002);
        tick();
        in_valid = 1'b0;
        chk("unblock_third_valid", 64'(out_valid), 64'h8);
        chk("unblock_third_data", 64'(out_data), 64'hC000_0003);
        tick();
        chk("unblock_drained", 64'(out_valid), 64'h0);
        chk("n4_never_drops", 64'(drop), 64'd0);

        // Reset with two flits queued
        out_ready = 4'b0000;
        in_valid = 1'b1; in_dest = 2'd0; in_data = 32'hE000_0001;
        tick();
        in_dest = 2'd1; in_data = 32'hE000_0002;
        tick();
        in_valid = 1'b0;
        chk("prerst_full", 64'(in_ready), 64'd0);
        chk("prerst_valid", 64'(out_valid), 64'h1);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_data", 64'(out_data), 64'h0);
        rst = 1'b0;
        out_ready = 4'b1111;
        tick();
        chk("postrst_no_flit0", 64'(out_valid), 64'h0);
        tick();
        chk("postrst_no_flit1", 64'(out_valid), 64'h0);

        // Out-of-range destination on the 3-port instance
        b_out_ready = 3'b111;
`ifdef DEST_PORT_DECODER_DROP_CNT_EN
        chk("cnt_start", 64'(b_drop_cnt), 64'd0);
`endif
        b_in_valid = 1'b1; b_in_dest = 2'd3; b_in_data = 32'hD000_0003;
        tick();
        b_in_valid = 1'b0;
        chk("oor_drop_pulse", 64'(b_drop), 64'd1);
        chk("oor_out_valid", 64'(b_out_valid), 64'h0);
        chk("oor_in_ready", 64'(b_in_ready), 64'd1);
`ifdef DEST_PORT_DECODER_DROP_CNT_EN
        chk("cnt_one", 64'(b_drop_cnt), 64'd1);
`endif
        tick();
        chk("oor_drop_cleared", 64'(b_drop), 64'd0);

        // Out-of-range accept in the same cycle as a send
        b_in_valid = 1'b1; b_in_dest = 2'd2; b_in_data = 32'hD000_0002;
        tick();
        chk("b_port2_valid", 64'(b_out_valid), 64'h4);
        chk("b_port2_data", 64'(b_out_data), 64'hD000_0002);
        b_in_dest = 2'd3; b_in_data = 32'hD000_0013;
        tick();
        b_in_valid = 1'b0;
        chk("oor_send_drop", 64'(b_drop), 64'd1);
        chk("oor_send_empty", 64'(b_out_valid), 64'h0);
        tick();
        chk("oor_send_drop_clear", 64'(b_drop), 64'd0);

`ifdef DEST_PORT_DECODER_DROP_CNT_EN
        chk("cnt_two", 64'(b_drop_cnt), 64'd2);
        chk("cnt_n4_zero", 64'(drop_cnt), 64'd0);
        // Saturation: hold an out-of-range flit for well over 65535 edges
        b_in_valid = 1'b1; b_in_dest = 2'd3;
        repeat (65540) @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("cnt_saturated", 64'(b_drop_cnt), 64'hFFFF);
        tick();
        chk("cnt_hold", 64'(b_drop_cnt), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
